// File: rtl/parity_stream.sv
`default_nettype none
// ============================================================================
//  Module      : parity_stream
//  Description : Pipelined even/odd parity generator and checker on a
//                valid/ready stream. It also tracks parity across a
//                multi-word frame and keeps a saturating count of parity
//                errors.
//  Options     : PARITY_STREAM_ERR_CNT_EN - when defined, build the err_cnt
//                counter and its clr input. When undefined, err_cnt is tied
//                to 0 and clr is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module parity_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d,
  input  logic             pin,
  input  logic             odd,
  input  logic             chk,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             p,
  output logic             err,
  output logic             fp,
  output logic             flast,
  input  logic             clr,
  output logic [CNT_W-1:0] err_cnt
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             p_q, p_d;
  logic             err_q, err_d;
  logic             fp_q, fp_d;
  logic             flast_q, flast_d;
  logic             acc_q, acc_d;
  logic             accept;
  logic             word_par;
  logic             word_err;

  // One-entry output register: accept whenever it is empty or draining now.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign word_par = ^d;
  assign word_err = chk & (word_par ^ pin ^ odd);

  // Next-state of the output register and the frame accumulator.
  always_comb begin
    out_valid_d = out_valid_q;
    data_d      = data_q;
    p_d         = p_q;
    err_d       = err_q;
    fp_d        = fp_q;
    flast_d     = flast_q;
    acc_d       = acc_q;
    if (accept) begin
      out_valid_d = 1'b1;
      data_d      = d;
      p_d         = word_par ^ odd;
      err_d       = word_err;
      flast_d     = last;
      if (last) begin
        // The odd bit of the closing word sets the frame's parity sense.
        fp_d  = acc_q ^ word_par ^ odd;
        acc_d = 1'b0;
      end else begin
        fp_d  = 1'b0;
        acc_d = acc_q ^ word_par;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register and accumulator state.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      p_q         <= 1'b0;
      err_q       <= 1'b0;
      fp_q        <= 1'b0;
      flast_q     <= 1'b0;
      acc_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      p_q         <= p_d;
      err_q       <= err_d;
      fp_q        <= fp_d;
      flast_q     <= flast_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign q         = data_q;
  assign p         = p_q;
  assign err       = err_q;
  assign fp        = fp_q;
  assign flast     = flast_q;

`ifdef PARITY_STREAM_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Saturating error count; clr wins over a same-cycle increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr) begin
      err_cnt_d = '0;
    end else if (accept && word_err && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // Error counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign err_cnt    = '0;
`endif

endmodule
`default_nettype wire
